// File: rtl/masked_single_port_ram.sv
// Single-port RAM with per-slice write mask, 1- or 2-cycle registered read and a
// sequential init engine that fills every word with INIT_VALUE after reset.
module masked_single_port_ram #(
    parameter int               WIDTH         = 32,
    parameter int               DEPTH         = 16,
    parameter int               ADDRESS_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int               SLICE_WIDTH   = 8,
    parameter int               READ_LATENCY  = 1,
    parameter int               WRITE_FIRST   = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           write_enable,
    input  logic                           read_enable,
    input  logic [ADDRESS_WIDTH-1:0]       address,
    input  logic [WIDTH-1:0]               write_data,
    input  logic [WIDTH/SLICE_WIDTH-1:0]   write_mask,
    output logic [WIDTH-1:0]               read_data,
    output logic                           read_valid,
    output logic                           ready
);

    localparam int SLICES = WIDTH / SLICE_WIDTH;

    if (WIDTH % SLICE_WIDTH != 0) begin : g_bad_slice_width
        $error("masked_single_port_ram: WIDTH must be a multiple of SLICE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
        $error("masked_single_port_ram: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

    state_t                   state;
    state_t                   next_state;
    logic [ADDRESS_WIDTH-1:0] init_counter;
    logic                     init_last;
    logic                     init_active;

    logic [WIDTH-1:0]         memory [DEPTH];
    logic [SLICES-1:0]        mem_slice_we;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [WIDTH-1:0]         mem_wdata;

    logic                     in_range;
    logic                     do_read;
    logic [WIDTH-1:0]         merged_word;
    logic [WIDTH-1:0]         read_word;
    logic                     stage1_valid;
    logic [WIDTH-1:0]         stage1_data;

    assign init_last = (init_counter == ADDRESS_WIDTH'(DEPTH - 1));
    assign in_range  = (32'(address) < DEPTH);
    assign do_read   = ready && read_enable;

    always_ff @(posedge clock) begin
        if (!resetn) state <= INIT;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == INIT && init_last) next_state = READY;
    end

    always_comb begin
        ready       = (state == READY);
        init_active = (state == INIT);
    end

    always_ff @(posedge clock) begin
        if (!resetn)          init_counter <= '0;
        else if (init_active) init_counter <= init_counter + 1'b1;
    end

    // One shared write port: the init engine owns it until READY, then user writes.
    always_comb begin
        mem_slice_we = '0;
        mem_address  = address;
        mem_wdata    = write_data;
        if (resetn) begin
            if (init_active) begin
                mem_slice_we = '1;
                mem_address  = init_counter;
                mem_wdata    = INIT_VALUE;
            end else if (write_enable && in_range) begin
                mem_slice_we = write_mask;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int s = 0; s < SLICES; s++) begin
            if (mem_slice_we[s])
                memory[mem_address][s*SLICE_WIDTH +: SLICE_WIDTH] <= mem_wdata[s*SLICE_WIDTH +: SLICE_WIDTH];
        end
    end

    always_comb begin
        merged_word = memory[address];
        for (int s = 0; s < SLICES; s++) begin
            if (write_mask[s])
                merged_word[s*SLICE_WIDTH +: SLICE_WIDTH] = write_data[s*SLICE_WIDTH +: SLICE_WIDTH];
        end
        if (!in_range)                            read_word = '0;
        else if (WRITE_FIRST != 0 && write_enable) read_word = merged_word;
        else                                      read_word = memory[address];
    end

    // Data registers load only on a valid beat so read_data holds between reads.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            stage1_valid <= 1'b0;
            stage1_data  <= '0;
        end else begin
            stage1_valid <= do_read;
            if (do_read) stage1_data <= read_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_latency2
        logic             stage2_valid;
        logic [WIDTH-1:0] stage2_data;

        always_ff @(posedge clock) begin
            if (!resetn) begin
                stage2_valid <= 1'b0;
                stage2_data  <= '0;
            end else begin
                stage2_valid <= stage1_valid;
                if (stage1_valid) stage2_data <= stage1_data;
            end
        end

        assign read_valid = stage2_valid;
        assign read_data  = stage2_data;
    end else begin : g_latency1
        assign read_valid = stage1_valid;
        assign read_data  = stage1_data;
    end

endmodule
